// File: rtl/rsa_modexp_core.sv
// Montgomery modular exponentiation o_ans = i_msg^i_key mod i_n (right-to-left binary method).
// Square and multiply units run every exponent bit, so latency never depends on the key.
module rsa_modexp_core #(
  parameter int WIDTH     = 256,
  parameter int EXP_WIDTH = WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [WIDTH-1:0]     i_msg,
  input  logic [EXP_WIDTH-1:0] i_key,
  input  logic [WIDTH-1:0]     i_n,
  input  logic                 i_abort,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [WIDTH-1:0]     o_ans,
  output logic                 o_err,
  output logic                 o_busy,
  output logic [2:0]           o_dbg_state
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(WIDTH);
  localparam int BW = $clog2(EXP_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_PREP = 3'd1, S_MONT = 3'd2, S_UPD = 3'd3, S_DONE = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     n_r, t_r, ans_r;
  logic [EXP_WIDTH-1:0] key_r;
  logic [WIDTH+1:0]     m_sqr, m_mul;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 err_r;

  logic                 op_err;
  logic [WIDTH:0]       dbl, dbl_red;
  logic [IW-1:0]        idx;
  logic [WIDTH+1:0]     sqr_step, mul_step, sqr_fin, mul_fin;

  // One radix-2 Montgomery iteration; m stays below 2n when a, b < n.
  function automatic logic [WIDTH+1:0] mont_step(input logic [WIDTH+1:0] m, input logic a_bit,
                                                 input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] n);
    logic [WIDTH+1:0] s;
    s = m + (a_bit ? {2'b00, b} : '0);
    s = s + (s[0] ? {2'b00, n} : '0);
    return s >> 1;
  endfunction

  always_comb begin
    op_err   = !i_n[0] || (i_n < WIDTH'(3)) || (i_msg >= i_n);
    dbl      = {t_r, 1'b0};
    dbl_red  = (dbl >= {1'b0, n_r}) ? dbl - {1'b0, n_r} : dbl;
    idx      = cnt[IW-1:0];
    sqr_step = mont_step(m_sqr, t_r[idx], t_r, n_r);
    mul_step = mont_step(m_mul, ans_r[idx], t_r, n_r);
    sqr_fin  = (m_sqr >= {2'b00, n_r}) ? m_sqr - {2'b00, n_r} : m_sqr;
    mul_fin  = (m_mul >= {2'b00, n_r}) ? m_mul - {2'b00, n_r} : m_mul;
  end

  // Handshakes: a transfer happens on the rising edge where valid && ready are both high;
  // o_in_ready is high only in IDLE and o_out_valid only in DONE, where o_ans/o_err stay frozen.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (i_in_valid) state_d = op_err ? S_DONE : S_PREP;
      S_PREP: if (cnt == CW'(WIDTH - 1)) state_d = S_MONT;
      S_MONT: if (cnt == CW'(WIDTH)) state_d = S_UPD;
      S_UPD:  state_d = (bit_cnt == BW'(EXP_WIDTH - 1)) ? S_DONE : S_MONT;
      S_DONE: if (i_out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (i_abort && state_q != S_IDLE) state_d = S_IDLE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ans stays in the normal domain: mont(ans, x*R) = ans*x, so no final conversion is needed.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      n_r     <= '0;
      t_r     <= '0;
      ans_r   <= '0;
      key_r   <= '0;
      m_sqr   <= '0;
      m_mul   <= '0;
      cnt     <= '0;
      bit_cnt <= '0;
      err_r   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (i_in_valid) begin
          n_r     <= i_n;
          key_r   <= i_key;
          t_r     <= i_msg;
          ans_r   <= op_err ? '0 : WIDTH'(1);
          err_r   <= op_err;
          cnt     <= '0;
          bit_cnt <= '0;
        end
        S_PREP: begin
          t_r <= dbl_red[WIDTH-1:0];
          if (cnt == CW'(WIDTH - 1)) begin
            cnt   <= '0;
            m_sqr <= '0;
            m_mul <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_MONT: if (cnt == CW'(WIDTH)) begin
          m_sqr <= sqr_fin;
          m_mul <= mul_fin;
          cnt   <= '0;
        end else begin
          m_sqr <= sqr_step;
          m_mul <= mul_step;
          cnt   <= cnt + CW'(1);
        end
        S_UPD: begin
          t_r <= m_sqr[WIDTH-1:0];
          if (key_r[0]) ans_r <= m_mul[WIDTH-1:0];
          key_r   <= key_r >> 1;
          bit_cnt <= bit_cnt + BW'(1);
          m_sqr   <= '0;
          m_mul   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign o_in_ready  = (state_q == S_IDLE);
  assign o_out_valid = (state_q == S_DONE);
  assign o_busy      = (state_q != S_IDLE);
  assign o_ans       = (state_q == S_DONE) ? ans_r : '0;
  assign o_err       = (state_q == S_DONE) && err_r;
  assign o_dbg_state = state_q;
endmodule

// File: tb/tb_rsa_modexp_core.sv
// Bench for rsa_modexp_core: an 8-bit instance for directed/abort/reset scenarios and a
// 32-bit instance for randomized operands checked against a plain modular-arithmetic model.
module tb_rsa_modexp_core;
  localparam int W  = 8;
  localparam int WW = 32;
  localparam int WE = 16;
  localparam int L8 = 1 + W + W * (W + 2);
  localparam int LW = 1 + WW + WE * (WW + 2);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic abort = 1'b0;
  logic out_ready = 1'b1;

  logic in_valid = 1'b0;
  logic [W-1:0] msg = '0, key = '0, n_i = '0;
  logic in_ready, out_valid, err, busy;
  logic [W-1:0] ans;
  logic [2:0] dbg;

  logic in_valid_w = 1'b0;
  logic [WW-1:0] msg_w = '0, n_w = '0;
  logic [WE-1:0] key_w = '0;
  logic in_ready_w, out_valid_w, err_w, busy_w;
  logic [WW-1:0] ans_w;
  logic [2:0] dbg_w;

  int checks = 0;
  int failures = 0;
  logic [W:0]  exp_q[$];
  logic [WW:0] exp_w_q[$];

  always #5 clk = ~clk;

  rsa_modexp_core #(.WIDTH(W), .EXP_WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_msg(msg), .i_key(key), .i_n(n_i), .i_abort(abort), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_ans(ans), .o_err(err), .o_busy(busy), .o_dbg_state(dbg)
  );

  rsa_modexp_core #(.WIDTH(WW), .EXP_WIDTH(WE)) dut_w (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid_w), .o_in_ready(in_ready_w),
    .i_msg(msg_w), .i_key(key_w), .i_n(n_w), .i_abort(abort), .o_out_valid(out_valid_w),
    .i_out_ready(out_ready), .o_ans(ans_w), .o_err(err_w), .o_busy(busy_w), .o_dbg_state(dbg_w)
  );

  function automatic logic [31:0] model(input logic [31:0] m, input logic [31:0] k, input logic [31:0] n);
    logic [63:0] r, b, nn;
    nn = {32'd0, n};
    r  = 64'd1 % nn;
    b  = {32'd0, m} % nn;
    for (int i = 0; i < 32; i++) begin
      if (k[i]) r = (r * b) % nn;
      b = (b * b) % nn;
    end
    return r[31:0];
  endfunction

  task automatic send8(input logic [W-1:0] m, input logic [W-1:0] k, input logic [W-1:0] n);
    logic e;
    logic [31:0] r;
    int w;
    e = !n[0] || (n < 8'd3) || (m >= n);
    r = 32'd0;
    if (!e) r = model({24'd0, m}, {24'd0, k}, {24'd0, n});
    exp_q.push_back({e, r[7:0]});
    w = 0;
    while (!in_ready && w < 1000) begin @(posedge clk); #1; w++; end
    in_valid = 1'b1; msg = m; key = k; n_i = n;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait8(output int lat);
    lat = 1;
    while (!out_valid && lat < 400) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic run8(input logic [W-1:0] m, input logic [W-1:0] k, input logic [W-1:0] n,
                      output logic [W:0] got, output logic [W:0] expv, output int lat);
    send8(m, k, n);
    wait8(lat);
    got  = {err, ans};
    expv = exp_q.pop_front();
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({in_ready, out_valid, ans, err, busy, dbg} !== {1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL reset8: got %b want %b", {in_ready, out_valid, ans, err, busy, dbg},
               {1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 3'd0});
    end
    checks++;
    if ({in_ready_w, out_valid_w, ans_w, err_w, busy_w, dbg_w} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL reset32: got %h want %h", {in_ready_w, out_valid_w, ans_w, err_w, busy_w, dbg_w},
               {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 3'd0});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [W:0] got, expv;
    int lat;
    run8(8'd5, 8'd7, 8'd143, got, expv, lat);
    checks++;
    if (got !== expv) begin failures++; $display("FAIL basic_sb: got %h want %h", got, expv); end
    checks++;
    if (got !== {1'b0, 8'd47}) begin failures++; $display("FAIL basic_47: got %h want %h", got, {1'b0, 8'd47}); end
    checks++;
    if (lat !== L8) begin failures++; $display("FAIL basic_lat: got %0d want %0d", lat, L8); end
  endtask

  task automatic test_key_zero;
    logic [W:0] got, expv;
    int lat;
    run8(8'd100, 8'd0, 8'd143, got, expv, lat);
    checks++;
    if (got !== {1'b0, 8'd1} || got !== expv) begin
      failures++; $display("FAIL key0_ans: got %h want %h", got, {1'b0, 8'd1});
    end
    checks++;
    if (lat !== L8) begin failures++; $display("FAIL key0_lat: got %0d want %0d", lat, L8); end
    run8(8'd0, 8'd9, 8'd143, got, expv, lat);
    checks++;
    if (got !== {1'b0, 8'd0} || got !== expv) begin
      failures++; $display("FAIL msg0_ans: got %h want %h", got, {1'b0, 8'd0});
    end
    checks++;
    if (lat !== L8) begin failures++; $display("FAIL msg0_lat: got %0d want %0d", lat, L8); end
  endtask

  task automatic test_error;
    logic [W-1:0] em[3];
    logic [W-1:0] en[3];
    logic [W:0] got, expv;
    int lat;
    em = '{8'd5, 8'd150, 8'd0};
    en = '{8'd142, 8'd143, 8'd1};
    for (int i = 0; i < 3; i++) begin
      run8(em[i], 8'd7, en[i], got, expv, lat);
      checks++;
      if (got !== {1'b1, 8'd0} || got !== expv) begin
        failures++; $display("FAIL err_resp[%0d]: got %h want %h", i, got, {1'b1, 8'd0});
      end
      checks++;
      if (lat !== 1) begin failures++; $display("FAIL err_lat[%0d]: got %0d want 1", i, lat); end
    end
  endtask

  task automatic test_random8;
    logic [W-1:0] m, k, n;
    logic [W:0] got, expv;
    int lat;
    for (int i = 0; i < 6; i++) begin
      n = 8'($urandom_range(3, 255)) | 8'd1;
      m = (i == 0) ? n - 8'd1 : 8'($urandom_range(0, int'(n) - 1));
      k = (i == 0) ? 8'hff : 8'($urandom_range(0, 255));
      run8(m, k, n, got, expv, lat);
      checks++;
      if (got !== expv || lat !== L8) begin
        failures++; $display("FAIL rand8[%0d] %0d^%0d mod %0d: got %h lat %0d want %h lat %0d",
                             i, m, k, n, got, lat, expv, L8);
      end
    end
  endtask

  task automatic test_wide;
    logic [WW-1:0] m, n;
    logic [WE-1:0] k;
    logic [WW:0] got, expv;
    int lat, w;
    for (int i = 0; i < 10; i++) begin
      n = $urandom() | 32'd1;
      if (n < 32'd3) n = 32'd3;
      m = (i == 1) ? n - 32'd1 : $urandom() % n;
      k = (i == 2) ? 16'hffff : 16'($urandom());
      exp_w_q.push_back({1'b0, model(m, {16'd0, k}, n)});
      if (i == 0) out_ready = 1'b0;
      w = 0;
      while (!in_ready_w && w < 1000) begin @(posedge clk); #1; w++; end
      in_valid_w = 1'b1; msg_w = m; key_w = k; n_w = n;
      @(posedge clk); #1;
      in_valid_w = 1'b0;
      lat = 1;
      while (!out_valid_w && lat < 2000) begin @(posedge clk); #1; lat++; end
      got  = {err_w, ans_w};
      expv = exp_w_q.pop_front();
      checks++;
      if (got !== expv || lat !== LW) begin
        failures++; $display("FAIL wide[%0d] %h^%h mod %h: got %h lat %0d want %h lat %0d",
                             i, m, k, n, got, lat, expv, LW);
      end
      if (i == 0) begin
        for (int j = 0; j < 10; j++) begin
          @(posedge clk); #1;
          checks++;
          if ({out_valid_w, err_w, ans_w} !== {1'b1, expv}) begin
            failures++; $display("FAIL wide_hold[%0d]: got %h want %h", j, {out_valid_w, err_w, ans_w}, {1'b1, expv});
          end
        end
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
      if (i == 0) begin
        checks++;
        if ({out_valid_w, in_ready_w, busy_w} !== 3'b010) begin
          failures++; $display("FAIL wide_handoff: got %b want 010", {out_valid_w, in_ready_w, busy_w});
        end
      end
    end
  endtask

  task automatic test_abort;
    logic [W:0] got, expv, dummy;
    int lat;
    logic seen;
    send8(8'd5, 8'd7, 8'd143);
    dummy = exp_q.pop_front();
    lat = 1;
    while (lat < 40) begin @(posedge clk); #1; lat++; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if ({busy, out_valid, in_ready} !== 3'b001) begin
      failures++; $display("FAIL abort_idle: got %b want 001", {busy, out_valid, in_ready});
    end
    seen = 1'b0;
    repeat (100) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL abort_novalid: got %b want 0", seen); end
    run8(8'd5, 8'd7, 8'd143, got, expv, lat);
    checks++;
    if (got !== {1'b0, 8'd47} || got !== expv) begin
      failures++; $display("FAIL abort_next: got %h want %h", got, {1'b0, 8'd47});
    end
    out_ready = 1'b0;
    send8(8'd9, 8'd3, 8'd143);
    wait8(lat);
    dummy = exp_q.pop_front();
    abort = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if ({lat == L8, busy, out_valid, err, ans, in_ready} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1}) begin
      failures++; $display("FAIL abort_done: got lat %0d %b want lat %0d 00000000001", lat,
                           {busy, out_valid, err, ans, in_ready}, L8);
    end
  endtask

  task automatic test_busy_ignore;
    logic [W:0] got, expv;
    int lat;
    send8(8'd5, 8'd7, 8'd143);
    lat = 1;
    while (!out_valid && lat < 400) begin
      if (lat == 5) begin in_valid = 1'b1; msg = 8'd3; key = 8'd3; n_i = 8'd11; end
      if (lat == 8) in_valid = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    got  = {err, ans};
    expv = exp_q.pop_front();
    checks++;
    if (got !== expv || got !== {1'b0, 8'd47} || lat !== L8) begin
      failures++; $display("FAIL busy_ignore: got %h lat %0d want %h lat %0d", got, lat, expv, L8);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({busy, in_ready} !== 2'b01) begin
      failures++; $display("FAIL busy_after: got %b want 01", {busy, in_ready});
    end
  endtask

  task automatic test_reset_mid;
    logic [W:0] got, expv, dummy;
    int lat;
    send8(8'd5, 8'd7, 8'd143);
    dummy = exp_q.pop_front();
    lat = 1;
    while (lat < 20) begin @(posedge clk); #1; lat++; end
    checks++;
    if ({busy, dbg} !== {1'b1, 3'd2}) begin
      failures++; $display("FAIL mid_state: got %b want 1010", {busy, dbg});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, ans, err, busy, dbg} !== {1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 3'd0}) begin
      failures++; $display("FAIL mid_reset: got %b want %b", {in_ready, out_valid, ans, err, busy, dbg},
                           {1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 3'd0});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    run8(8'd5, 8'd7, 8'd143, got, expv, lat);
    checks++;
    if (got !== expv || lat !== L8) begin
      failures++; $display("FAIL after_reset: got %h lat %0d want %h lat %0d", got, lat, expv, L8);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_key_zero();
    test_error();
    test_random8();
    test_wide();
    test_abort();
    test_busy_ignore();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
